// File: rtl/pwm_audio_decoder_pkg.sv
// Shared audio constants for the PWM generator and its receive-side decoder.
package pwm_audio_decoder_pkg;

    localparam int unsigned DefWindowBits = 8;
    localparam int unsigned DefPeriodBits = 16;

    // Square tone: base count 100 stepped by 4 gives the half-period in clocks.
    localparam int unsigned ToneBase         = 100;
    localparam int unsigned ToneStep         = 4;
    localparam int unsigned SquareHalfPeriod = ToneBase / ToneStep;
    localparam int unsigned SquarePeriod     = 2 * SquareHalfPeriod;

    localparam logic [7:0] LfsrSeed = 8'hA5;

endpackage

// File: rtl/pwm_audio_decoder_if.sv
// Sound stream in, duty and period measurements out.
interface pwm_audio_decoder_if
    import pwm_audio_decoder_pkg::*;
#(
    parameter int unsigned WINDOW_BITS = DefWindowBits,
    parameter int unsigned PERIOD_BITS = DefPeriodBits
);

    logic                   sound_in;
    logic [WINDOW_BITS:0]   sample;
    logic                   sample_valid;
    logic [PERIOD_BITS-1:0] period;
    logic                   period_valid;
    logic                   period_overflow;

    modport slave (
        input  sound_in,
        output sample,
        output sample_valid,
        output period,
        output period_valid,
        output period_overflow
    );

    modport master (
        output sound_in,
        input  sample,
        input  sample_valid,
        input  period,
        input  period_valid,
        input  period_overflow
    );

endinterface

// File: rtl/pwm_audio_decoder_edge_period_meter.sv
// Rising-edge-to-rising-edge period meter with a saturating counter and overflow flag.
module pwm_audio_decoder_edge_period_meter
    import pwm_audio_decoder_pkg::*;
#(
    parameter int unsigned PERIOD_BITS = DefPeriodBits
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_q_i,
    input  logic                   s_prev_i,
    output logic [PERIOD_BITS-1:0] period_o,
    output logic                   period_valid_o,
    output logic                   period_overflow_o
);

    logic                   rise;
    logic [PERIOD_BITS-1:0] per_cnt_q, per_cnt_d;
    logic [PERIOD_BITS-1:0] period_q, period_d;
    logic                   armed_q, armed_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    always_comb begin
        rise      = s_q_i & ~s_prev_i;
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        armed_d   = armed_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        if (rise) begin
            // The first edge after reset or overflow has no reference, so it only arms.
            if (armed_q && !ovf_q) begin
                period_d = per_cnt_q + PERIOD_BITS'(1);
                valid_d  = 1'b1;
            end
            per_cnt_d = '0;
            armed_d   = 1'b1;
            ovf_d     = 1'b0;
        end else if (&per_cnt_q) begin
            ovf_d   = 1'b1;
            armed_d = 1'b0;
        end else begin
            per_cnt_d = per_cnt_q + PERIOD_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt_q <= '0;
            period_q  <= '0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign period_o          = period_q;
    assign period_valid_o    = valid_q;
    assign period_overflow_o = ovf_q;

endmodule

// File: rtl/pwm_audio_decoder.sv
// Recovers windowed duty cycle and square-tone period from the 1-bit audio PWM stream.
module pwm_audio_decoder
    import pwm_audio_decoder_pkg::*;
#(
    parameter int unsigned WINDOW_BITS = DefWindowBits,
    parameter int unsigned PERIOD_BITS = DefPeriodBits
) (
    input logic                clk,
    input logic                reset,
    pwm_audio_decoder_if.slave bus
);

    logic                   s_q, s_prev;
    logic [WINDOW_BITS-1:0] win_cnt_q, win_cnt_d;
    logic [WINDOW_BITS:0]   acc_q, acc_d, acc_sum;
    logic [WINDOW_BITS:0]   sample_q, sample_d;
    logic                   sample_valid_q, sample_valid_d;

    always_comb begin
        // One extra bit of headroom lets a fully-high window read 2^WINDOW_BITS.
        acc_sum        = acc_q + (WINDOW_BITS + 1)'(s_q);
        win_cnt_d      = win_cnt_q + WINDOW_BITS'(1);
        acc_d          = acc_sum;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        if (&win_cnt_q) begin
            acc_d          = '0;
            sample_d       = acc_sum;
            sample_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q            <= 1'b0;
            s_prev         <= 1'b0;
            win_cnt_q      <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            s_q            <= bus.sound_in;
            s_prev         <= s_q;
            win_cnt_q      <= win_cnt_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    pwm_audio_decoder_edge_period_meter #(
        .PERIOD_BITS(PERIOD_BITS)
    ) u_period (
        .clk              (clk),
        .reset            (reset),
        .s_q_i            (s_q),
        .s_prev_i         (s_prev),
        .period_o         (bus.period),
        .period_valid_o   (bus.period_valid),
        .period_overflow_o(bus.period_overflow)
    );

    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;

endmodule
